// File: rtl/dallanma_cozum_birimi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dallanma_cozum_birimi_pkg
// Description : Branch type codes, resolver state encodings and helper.
// Revision    : 1.0 - initial release
// ============================================================================
package dallanma_cozum_birimi_pkg;

  localparam logic [3:0] BRA_BEQ  = 4'd0;
  localparam logic [3:0] BRA_BNE  = 4'd1;
  localparam logic [3:0] BRA_BLT  = 4'd2;
  localparam logic [3:0] BRA_BGE  = 4'd3;
  localparam logic [3:0] BRA_BLTU = 4'd4;
  localparam logic [3:0] BRA_BGEU = 4'd5;
  localparam logic [3:0] BRA_JAL  = 4'd6;
  localparam logic [3:0] BRA_JALR = 4'd7;

  localparam logic [0:0] ST_NORMAL = 1'b0;
  localparam logic [0:0] ST_OLDUR  = 1'b1;

  // Codes 8-15 are reserved and never resolved.
  function automatic logic tur_gecerli(input logic [3:0] tur);
    return ~tur[3];
  endfunction

endpackage
`default_nettype wire

// File: rtl/dallanma_karsilastirici.sv
`default_nettype none
// ============================================================================
// Module      : dallanma_karsilastirici
// Description : Combinational EQ / signed-LT / unsigned-LT direction decision.
// Revision    : 1.0 - initial release
// ============================================================================
module dallanma_karsilastirici
  import dallanma_cozum_birimi_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [3:0]      buy_turu_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic            atladi_o
);

  logic w_esit;
  logic w_kucuk_isaretli;
  logic w_kucuk_isaretsiz;

  assign w_esit            = (rs1_i == rs2_i);
  assign w_kucuk_isaretli  = ($signed(rs1_i) < $signed(rs2_i));
  assign w_kucuk_isaretsiz = (rs1_i < rs2_i);

  always_comb begin
    atladi_o = 1'b0;
    case (buy_turu_i)
      BRA_BEQ:  atladi_o = w_esit;
      BRA_BNE:  atladi_o = ~w_esit;
      BRA_BLT:  atladi_o = w_kucuk_isaretli;
      BRA_BGE:  atladi_o = ~w_kucuk_isaretli;
      BRA_BLTU: atladi_o = w_kucuk_isaretsiz;
      BRA_BGEU: atladi_o = ~w_kucuk_isaretsiz;
      BRA_JAL:  atladi_o = 1'b1;
      BRA_JALR: atladi_o = 1'b1;
      default:  atladi_o = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/dallanma_cozum_birimi.sv
`default_nettype none
// ============================================================================
// Module      : dallanma_cozum_birimi
// Description : Execute-stage branch/jump resolver with registered redirect,
//               predictor update and wrong-path kill window.
//               Optional perf counters: define DALLANMA_PERF_SAYAC_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module dallanma_cozum_birimi
  import dallanma_cozum_birimi_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned PS_W      = 32,
  parameter int unsigned OLU_DONGU = 2,
  parameter int unsigned SAYAC_W   = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              dur_i,
  input  logic              gecerli_i,
  input  logic [3:0]        buy_turu_i,
  input  logic [PS_W-1:0]   ps_i,
  input  logic [XLEN-1:0]   rs1_i,
  input  logic [XLEN-1:0]   rs2_i,
  input  logic [XLEN-1:0]   anlik_i,
  input  logic              ongoru_atladi_i,
  input  logic [PS_W-1:0]   ongoru_hedef_i,
  output logic              guncelle_gecerli_o,
  output logic              guncelle_atladi_o,
  output logic [PS_W-1:0]   guncelle_ps_o,
  output logic [PS_W-1:0]   guncelle_hedef_o,
  output logic              dallanma_hata_o,
  output logic [PS_W-1:0]   duzeltilmis_ps_o,
`ifdef DALLANMA_PERF_SAYAC_EN
  output logic [SAYAC_W-1:0] top_dallanma_o,
  output logic [SAYAC_W-1:0] hata_sayisi_o,
`endif
  output logic [PS_W-1:0]   baglanti_o
);

  localparam int unsigned SAYAC_K_W = (OLU_DONGU < 1) ? 1 : $clog2(OLU_DONGU + 1);

  logic [0:0]           durum_q, durum_d;
  logic [SAYAC_K_W-1:0] olu_sayac_q, olu_sayac_d;

  logic              guncelle_gecerli_q, guncelle_gecerli_d;
  logic              guncelle_atladi_q, guncelle_atladi_d;
  logic [PS_W-1:0]   guncelle_ps_q, guncelle_ps_d;
  logic [PS_W-1:0]   guncelle_hedef_q, guncelle_hedef_d;
  logic              hata_q, hata_d;
  logic [PS_W-1:0]   duzeltilmis_q, duzeltilmis_d;
  logic [PS_W-1:0]   baglanti_q, baglanti_d;

  logic              w_atladi;
  logic              w_kabul;
  logic              w_hata;
  logic [XLEN-1:0]   w_jalr_toplam;
  logic [PS_W-1:0]   w_hedef;
  logic [PS_W-1:0]   w_sirali_ps;

  dallanma_karsilastirici #(
    .XLEN (XLEN)
  ) u_karsilastirici (
    .buy_turu_i (buy_turu_i),
    .rs1_i      (rs1_i),
    .rs2_i      (rs2_i),
    .atladi_o   (w_atladi)
  );

  assign w_kabul       = gecerli_i & ~dur_i & (durum_q == ST_NORMAL) & tur_gecerli(buy_turu_i);
  assign w_jalr_toplam = rs1_i + anlik_i;
  assign w_hedef       = (buy_turu_i == BRA_JALR) ? {w_jalr_toplam[PS_W-1:1], 1'b0}
                                                  : ps_i + anlik_i[PS_W-1:0];
  assign w_sirali_ps   = ps_i + PS_W'(4);
  // A taken prediction with a stale target is as wrong as a wrong direction.
  assign w_hata        = (w_atladi != ongoru_atladi_i) |
                         (w_atladi & ongoru_atladi_i & (w_hedef != ongoru_hedef_i));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      durum_q     <= ST_NORMAL;
      olu_sayac_q <= '0;
    end else if (!dur_i) begin
      durum_q     <= durum_d;
      olu_sayac_q <= olu_sayac_d;
    end
  end

  always_comb begin
    durum_d     = durum_q;
    olu_sayac_d = olu_sayac_q;
    case (durum_q)
      ST_NORMAL: begin
        if (w_kabul && w_hata && (OLU_DONGU > 0)) begin
          durum_d     = ST_OLDUR;
          olu_sayac_d = SAYAC_K_W'(OLU_DONGU);
        end
      end
      ST_OLDUR: begin
        olu_sayac_d = olu_sayac_q - 1'b1;
        if (olu_sayac_q == SAYAC_K_W'(1)) begin
          durum_d = ST_NORMAL;
        end
      end
      default: durum_d = ST_NORMAL;
    endcase
  end

  always_comb begin
    guncelle_gecerli_d = w_kabul;
    hata_d             = w_kabul & w_hata;
    guncelle_atladi_d  = guncelle_atladi_q;
    guncelle_ps_d      = guncelle_ps_q;
    guncelle_hedef_d   = guncelle_hedef_q;
    duzeltilmis_d      = duzeltilmis_q;
    baglanti_d         = baglanti_q;
    if (w_kabul) begin
      guncelle_atladi_d = w_atladi;
      guncelle_ps_d     = ps_i;
      guncelle_hedef_d  = w_hedef;
      duzeltilmis_d     = w_atladi ? w_hedef : w_sirali_ps;
      baglanti_d        = w_sirali_ps;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      guncelle_gecerli_q <= 1'b0;
      guncelle_atladi_q  <= 1'b0;
      guncelle_ps_q      <= '0;
      guncelle_hedef_q   <= '0;
      hata_q             <= 1'b0;
      duzeltilmis_q      <= '0;
      baglanti_q         <= '0;
    end else if (!dur_i) begin
      guncelle_gecerli_q <= guncelle_gecerli_d;
      guncelle_atladi_q  <= guncelle_atladi_d;
      guncelle_ps_q      <= guncelle_ps_d;
      guncelle_hedef_q   <= guncelle_hedef_d;
      hata_q             <= hata_d;
      duzeltilmis_q      <= duzeltilmis_d;
      baglanti_q         <= baglanti_d;
    end
  end

  assign guncelle_gecerli_o = guncelle_gecerli_q;
  assign guncelle_atladi_o  = guncelle_atladi_q;
  assign guncelle_ps_o      = guncelle_ps_q;
  assign guncelle_hedef_o   = guncelle_hedef_q;
  assign dallanma_hata_o    = hata_q;
  assign duzeltilmis_ps_o   = duzeltilmis_q;
  assign baglanti_o         = baglanti_q;

`ifdef DALLANMA_PERF_SAYAC_EN
  logic [SAYAC_W-1:0] top_sayac_q;
  logic [SAYAC_W-1:0] hata_sayac_q;

  // Saturating; w_kabul already excludes stalls and the kill window.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      top_sayac_q  <= '0;
      hata_sayac_q <= '0;
    end else begin
      if (w_kabul && (top_sayac_q != '1)) begin
        top_sayac_q <= top_sayac_q + 1'b1;
      end
      if (w_kabul && w_hata && (hata_sayac_q != '1)) begin
        hata_sayac_q <= hata_sayac_q + 1'b1;
      end
    end
  end

  assign top_dallanma_o = top_sayac_q;
  assign hata_sayisi_o  = hata_sayac_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dallanma_cozum_birimi.sv
`default_nettype none
// ============================================================================
// Module      : tb_dallanma_cozum_birimi
// Description : Directed self-checking bench for dallanma_cozum_birimi.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dallanma_cozum_birimi;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        dur_i;
  logic        gecerli_i;
  logic [3:0]  buy_turu_i;
  logic [31:0] ps_i, rs1_i, rs2_i, anlik_i, ongoru_hedef_i;
  logic        ongoru_atladi_i;
  logic        guncelle_gecerli_o, guncelle_atladi_o, dallanma_hata_o;
  logic [31:0] guncelle_ps_o, guncelle_hedef_o, duzeltilmis_ps_o, baglanti_o;
`ifdef DALLANMA_PERF_SAYAC_EN
  logic [31:0] top_dallanma_o, hata_sayisi_o;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_i = ~clk_i;

  dallanma_cozum_birimi dut (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .dur_i              (dur_i),
    .gecerli_i          (gecerli_i),
    .buy_turu_i         (buy_turu_i),
    .ps_i               (ps_i),
    .rs1_i              (rs1_i),
    .rs2_i              (rs2_i),
    .anlik_i            (anlik_i),
    .ongoru_atladi_i    (ongoru_atladi_i),
    .ongoru_hedef_i     (ongoru_hedef_i),
    .guncelle_gecerli_o (guncelle_gecerli_o),
    .guncelle_atladi_o  (guncelle_atladi_o),
    .guncelle_ps_o      (guncelle_ps_o),
    .guncelle_hedef_o   (guncelle_hedef_o),
    .dallanma_hata_o    (dallanma_hata_o),
    .duzeltilmis_ps_o   (duzeltilmis_ps_o),
`ifdef DALLANMA_PERF_SAYAC_EN
    .top_dallanma_o     (top_dallanma_o),
    .hata_sayisi_o      (hata_sayisi_o),
`endif
    .baglanti_o         (baglanti_o)
  );

  task automatic chk(input string tag, input logic [63:0] gozlenen, input logic [63:0] beklenen);
    n_checks++;
    if (gozlenen !== beklenen) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, gozlenen, beklenen);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic sur(input logic g, input logic [3:0] t, input logic [31:0] ps,
                     input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                     input logic pa, input logic [31:0] ph);
    gecerli_i       = g;
    buy_turu_i      = t;
    ps_i            = ps;
    rs1_i           = a;
    rs2_i           = b;
    anlik_i         = imm;
    ongoru_atladi_i = pa;
    ongoru_hedef_i  = ph;
  endtask

  task automatic chk_sifir(input string tag);
    chk({tag, "_gg"},   64'(guncelle_gecerli_o), 64'd0);
    chk({tag, "_ga"},   64'(guncelle_atladi_o),  64'd0);
    chk({tag, "_gps"},  64'(guncelle_ps_o),      64'd0);
    chk({tag, "_ghd"},  64'(guncelle_hedef_o),   64'd0);
    chk({tag, "_hata"}, 64'(dallanma_hata_o),    64'd0);
    chk({tag, "_duz"},  64'(duzeltilmis_ps_o),   64'd0);
    chk({tag, "_bag"},  64'(baglanti_o),         64'd0);
  endtask

  initial begin
    rst_i = 1'b1;
    dur_i = 1'b0;
    sur(1'b0, 4'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    repeat (2) step();
    chk_sifir("reset");
    rst_i = 1'b0;

    // BEQ taken, predicted not-taken -> redirect to 0x120
    sur(1'b1, 4'd0, 32'h100, 32'd5, 32'd5, 32'h20, 1'b0, 32'h0);
    step();
    chk("beq_gg",   64'(guncelle_gecerli_o), 64'd1);
    chk("beq_hata", 64'(dallanma_hata_o),    64'd1);
    chk("beq_at",   64'(guncelle_atladi_o),  64'd1);
    chk("beq_duz",  64'(duzeltilmis_ps_o),   64'h120);
    chk("beq_gps",  64'(guncelle_ps_o),      64'h100);
    chk("beq_bag",  64'(baglanti_o),         64'h104);
    gecerli_i = 1'b0;
    step();
    chk("idle_gg",   64'(guncelle_gecerli_o), 64'd0);
    chk("idle_hata", 64'(dallanma_hata_o),    64'd0);
    chk("idle_duz",  64'(duzeltilmis_ps_o),   64'h120);
    step();

    // BLT signed -1<1 taken and correct, then BLTU not taken -> mispredict
    sur(1'b1, 4'd2, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h40, 1'b1, 32'h240);
    step();
    chk("blt_gg",   64'(guncelle_gecerli_o), 64'd1);
    chk("blt_at",   64'(guncelle_atladi_o),  64'd1);
    chk("blt_hata", 64'(dallanma_hata_o),    64'd0);
    chk("blt_ghd",  64'(guncelle_hedef_o),   64'h240);
    sur(1'b1, 4'd4, 32'h300, 32'hFFFF_FFFF, 32'd1, 32'h40, 1'b1, 32'h340);
    step();
    chk("bltu_gg",   64'(guncelle_gecerli_o), 64'd1);
    chk("bltu_at",   64'(guncelle_atladi_o),  64'd0);
    chk("bltu_hata", 64'(dallanma_hata_o),    64'd1);
    chk("bltu_duz",  64'(duzeltilmis_ps_o),   64'h304);

    // Three consecutive BNEs after redirect: two killed, third accepted
    sur(1'b1, 4'd1, 32'h400, 32'd1, 32'd2, 32'h8, 1'b1, 32'h408);
    step();
    chk("kill1_gg", 64'(guncelle_gecerli_o), 64'd0);
    step();
    chk("kill2_gg", 64'(guncelle_gecerli_o), 64'd0);
    step();
    chk("bne_gg",   64'(guncelle_gecerli_o), 64'd1);
    chk("bne_gps",  64'(guncelle_ps_o),      64'h400);
    chk("bne_hata", 64'(dallanma_hata_o),    64'd0);

    // JALR target bit 0 cleared, predicted 0x2004 -> mispredict
    sur(1'b1, 4'd7, 32'h500, 32'h2001, 32'd0, 32'h0, 1'b1, 32'h2004);
    step();
    chk("jalr_hata", 64'(dallanma_hata_o),  64'd1);
    chk("jalr_ghd",  64'(guncelle_hedef_o), 64'h2000);
    chk("jalr_duz",  64'(duzeltilmis_ps_o), 64'h2000);
    chk("jalr_bag",  64'(baglanti_o),       64'h504);

    // Kill window stretched by one stalled cycle
    sur(1'b1, 4'd6, 32'h600, 32'd0, 32'd0, 32'h10, 1'b1, 32'h610);
    step();
    chk("kw1_gg", 64'(guncelle_gecerli_o), 64'd0);
    dur_i = 1'b1;
    step();
    chk("kw_stall_gg", 64'(guncelle_gecerli_o), 64'd0);
    dur_i = 1'b0;
    step();
    chk("kw2_gg", 64'(guncelle_gecerli_o), 64'd0);
    step();
    chk("jal_gg",   64'(guncelle_gecerli_o), 64'd1);
    chk("jal_gps",  64'(guncelle_ps_o),      64'h600);
    chk("jal_bag",  64'(baglanti_o),         64'h604);
    chk("jal_hata", 64'(dallanma_hata_o),    64'd0);

    // BGE equal with negative offset, then stall holds outputs
    sur(1'b1, 4'd3, 32'h700, 32'd3, 32'd3, 32'hFFFF_FFFC, 1'b1, 32'h6FC);
    step();
    chk("bge_gg",  64'(guncelle_gecerli_o), 64'd1);
    chk("bge_ghd", 64'(guncelle_hedef_o),   64'h6FC);
    sur(1'b1, 4'd0, 32'h780, 32'd1, 32'd2, 32'h4, 1'b0, 32'h0);
    dur_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("stall_gg",  64'(guncelle_gecerli_o), 64'd1);
      chk("stall_gps", 64'(guncelle_ps_o),      64'h700);
    end
    dur_i = 1'b0;
    gecerli_i = 1'b0;
    step();
    chk("post_stall_gg", 64'(guncelle_gecerli_o), 64'd0);

    // Invalid encoding ignored, data held
    sur(1'b1, 4'd9, 32'h900, 32'd1, 32'd1, 32'h4, 1'b0, 32'h0);
    step();
    chk("inv_gg",   64'(guncelle_gecerli_o), 64'd0);
    chk("inv_hata", 64'(dallanma_hata_o),    64'd0);
    chk("inv_gps",  64'(guncelle_ps_o),      64'h700);

    // BGEU 1>=2 false, predicted not-taken; target wraps
    sur(1'b1, 4'd5, 32'hFFFF_FFF0, 32'd1, 32'd2, 32'h20, 1'b0, 32'h0);
    step();
    chk("bgeu_gg",   64'(guncelle_gecerli_o), 64'd1);
    chk("bgeu_at",   64'(guncelle_atladi_o),  64'd0);
    chk("bgeu_hata", 64'(dallanma_hata_o),    64'd0);
    chk("bgeu_ghd",  64'(guncelle_hedef_o),   64'h10);
    chk("bgeu_bag",  64'(baglanti_o),         64'hFFFF_FFF4);

    // JAL wrong target, then async reset inside the kill window
    sur(1'b1, 4'd6, 32'h800, 32'd0, 32'd0, 32'h100, 1'b1, 32'h804);
    step();
    chk("jal2_hata", 64'(dallanma_hata_o),  64'd1);
    chk("jal2_duz",  64'(duzeltilmis_ps_o), 64'h900);
    #2 rst_i = 1'b1;
    #1 chk_sifir("async_rst");
    #1 rst_i = 1'b0;
    sur(1'b1, 4'd0, 32'hA00, 32'd7, 32'd7, 32'h8, 1'b1, 32'hA08);
    step();
    chk("after_rst_gg",   64'(guncelle_gecerli_o), 64'd1);
    chk("after_rst_gps",  64'(guncelle_ps_o),      64'hA00);
    chk("after_rst_hata", 64'(dallanma_hata_o),    64'd0);
`ifdef DALLANMA_PERF_SAYAC_EN
    chk("perf_top",  64'(top_dallanma_o), 64'd1);
    chk("perf_hata", 64'(hata_sayisi_o),  64'd0);
`endif
    gecerli_i = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dallanma_cozum_birimi.md
Name: dallanma_cozum_birimi

Overview:
- Parametrised branch/jump resolution unit in the execute stage.
- Resolves all conditional branches plus JAL/JALR with its own comparator, so it no longer depends on ALU flags.
- Detects both direction and target mispredictions and produces a registered redirect and predictor-update bundle.
- Masks wrong-path instructions for a configurable window after each redirect.

Parameters:
- XLEN, 32, operand width of rs1/rs2/immediate.
- PS_W, 32, program counter width (PS_W <= XLEN).
- OLU_DONGU, 2, number of accepted (non-stalled) cycles masked after a redirect; 0 disables masking.
- SAYAC_W, 32, performance counter width (only used with the optional feature).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- dur_i  in  1  pipeline stall; block holds all state and outputs.
- gecerli_i  in  1  branch/jump instruction present this cycle.
- buy_turu_i  in  4  0 BEQ, 1 BNE, 2 BLT, 3 BGE, 4 BLTU, 5 BGEU, 6 JAL, 7 JALR, 8-15 invalid.
- ps_i  in  PS_W  PC of the instruction.
- rs1_i  in  XLEN  source operand 1.
- rs2_i  in  XLEN  source operand 2.
- anlik_i  in  XLEN  sign-extended immediate.
- ongoru_atladi_i  in  1  predictor said taken.
- ongoru_hedef_i  in  PS_W  predicted target.
- guncelle_gecerli_o  out  1  predictor update valid.
- guncelle_atladi_o  out  1  actual direction.
- guncelle_ps_o  out  PS_W  PC being updated.
- guncelle_hedef_o  out  PS_W  actual target.
- dallanma_hata_o  out  1  misprediction; fetch redirect request.
- duzeltilmis_ps_o  out  PS_W  redirect PC.
- baglanti_o  out  PS_W  link value ps_i+4, used for JAL/JALR writeback.

Behaviour:
- All outputs are registered, with 1-cycle latency from an accepted input.
- Reset: every output is 0, the kill counter is 0, and the state is NORMAL. Reset applies asynchronously mid-operation and discards any pending kill window.
- Accept condition: gecerli_i & !dur_i & state==NORMAL.
- While dur_i=1: no register changes, including the kill counter and perf counters. Outputs hold their values.
- Direction:
  - BEQ: rs1==rs2.
  - BNE: rs1!=rs2.
  - BLT/BGE: signed less-than, or its negation.
  - BLTU/BGEU: unsigned less-than, or its negation.
  - JAL/JALR: always taken.
- Target:
  - Branches and JAL: ps_i+anlik_i[PS_W-1:0], modulo 2^PS_W (wrap allowed).
  - JALR: (rs1_i+anlik_i) with bit 0 cleared, truncated to PS_W.
- Misprediction when either holds:
  - atladi != ongoru_atladi_i, or
  - atladi & ongoru_atladi_i & hedef != ongoru_hedef_i.
- Redirect PC: atladi ? hedef : ps_i+4.
- On an accepted valid encoding:
  - guncelle_gecerli_o=1 for one non-stalled cycle.
  - guncelle_* and baglanti_o are loaded.
  - dallanma_hata_o=1 only on misprediction.
- Invalid encoding (8-15): treated as not accepted; all pulses are 0.
- No accept: pulses (guncelle_gecerli_o, dallanma_hata_o) return to 0; data outputs hold their last values.
- State machine:
  - NORMAL -> OLDUR when dallanma_hata is issued and OLU_DONGU>0; the counter is loaded with OLU_DONGU.
  - OLDUR: every non-stalled cycle decrements the counter, and gecerli_i is ignored (no pulses). At counter==1 with !dur_i, return to NORMAL.
  - A gecerli_i arriving on the same cycle the counter expires is also ignored; the first accepted input is on the following cycle.
- Back-to-back accepted branches in NORMAL without misprediction produce consecutive update pulses.

Optional Feature:
- Macro DALLANMA_PERF_SAYAC_EN.
- When defined, adds outputs top_dallanma_o and hata_sayisi_o, both SAYAC_W wide.
  - top_dallanma_o counts accepted resolutions.
  - hata_sayisi_o counts mispredictions.
  - Both saturate at all-ones, do not count while dur_i or while in OLDUR, and reset to 0.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package/include, extending operations.vh:
  - BRA_* codes 0-7.
  - State encodings NORMAL/OLDUR.
- One sub-module, dallanma_karsilastirici: combinational EQ/signed-LT/unsigned-LT producing the direction bit for a given type.
- Target and misprediction logic stay in the top module.

Test Plan:
- BEQ, rs1=rs2=5, predicted not-taken, ps=0x100, imm=0x20:
  - Next cycle: hata=1, atladi=1, duzeltilmis_ps=0x120, guncelle_gecerli=1.
- BLT, rs1=0xFFFFFFFF, rs2=1 (signed -1<1) vs BLTU with the same operands:
  - BLT: taken. BLTU: not taken. Both predicted taken, so hata only on BLTU with redirect ps+4.
- JALR, rs1=0x2001, imm=0, predicted taken with target 0x2004:
  - hedef=0x2000, hata=1, baglanti=ps+4.
- Redirect followed by 3 consecutive gecerli_i with OLU_DONGU=2:
  - First two ignored (no pulses); third accepted.
  - Inserting dur_i=1 mid-window extends the window by the stalled cycles.
- dur_i high on the cycle after an accept:
  - Outputs hold for the stalled cycles.
  - No double counting of pulses downstream or in the perf counters.
- Assert rst_i asynchronously in OLDUR with pending outputs:
  - All outputs 0 immediately; the next gecerli_i after release is accepted.
